stag3_folded: RTL and testbench
===============================

# stag3_folded

Folded Stage-3 processor of the 16-point radix-2 DIF FFT. It sits directly downstream of Stage 2 and takes Stage 2's 16-word frame bus. It performs the eight stride-2 butterflies with two shared butterfly units over four cycles, and presents the finished frame to Stage 4. A valid/ready handshake on both sides replaces the free-running `en`-only pipelining of the fully parallel stages.

## Interface
Parameters:
- `N_PTS`, 16: points per frame. Fixed; any other value is not supported.
- `WORD_W`, 32: complex word width, `{re[31:16], im[15:0]}`, both halves signed.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset. One clock; reset is synchronous and active-high.
- `en`, in, 1: global advance enable. When low, all state freezes.
- `in_valid`, in, 1: `Bus_in` holds a frame.
- `in_ready`, out, 1: block accepts a frame this cycle.
- `Bus_in`, in, 512: Stage-2 frame. `Din[i] = Bus_in[32i+31:32i]`.
- `out_valid`, out, 1: `Bus_out` holds a finished frame.
- `out_ready`, in, 1: Stage 4 accepts the frame.
- `Bus_out`, out, 512: result frame. `Dout[i] = Bus_out[32i+31:32i]`.

## Operation
- **States:**
  - IDLE: waiting for a frame.
  - RUN: 2-bit group counter `k` counts 0..3.
  - DONE: result held for Stage 4.
- **Handshakes (`en`=1):**
  - `in_ready` = (IDLE) | (DONE & `out_ready`).
  - Accept = `in_valid` & `in_ready`. It loads all 16 words into the frame register, sets `k`=0, and moves to RUN.
  - `out_valid` = DONE.
  - Output handshake = `out_valid` & `out_ready`. DONE goes to IDLE, or to RUN if a frame is accepted in the same cycle.
- **RUN cycle `k`** processes group `k`:
  - Unit A: top `Din[4k]`, bottom `Din[4k+2]`, twiddle `TW_0`. Results go to `Dout[4k]` and `Dout[4k+2]`.
  - Unit B: top `Din[4k+1]`, bottom `Din[4k+3]`, twiddle `TW_4`. Results go to `Dout[4k+1]` and `Dout[4k+3]`.
  - At `k`=3 the state moves to DONE.
- **Butterfly arithmetic:** as computed by `SandeTukey`.
  - X = A+B.
  - Y = (A−B)·W, with W in Q2.14 and the product shifted right arithmetically by 14 per component.
  - No extra scaling or saturation in this block.
- **Twiddles:**
  - `TW_0` = 32'h4000_0000 (1).
  - `TW_4` = 32'h0000_C000 (−j).
- **`en`=0:**
  - State, `k`, frame register and result register all hold.
  - `in_ready` and `out_valid` are forced to 0, so no handshake completes.
- **Reset:**
  - While `reset` is high: state = IDLE, `k`=0, frame register = 0, result register = 0.
  - `in_ready`=0 and `out_valid`=0 while `reset` is high.
  - From the first cycle after deassertion: `in_ready`=1 and `Bus_out`=0.
  - Reset mid-RUN or mid-DONE discards the frame with no output.
- **`Bus_out` contents:** meaningful only while `out_valid`=1. During RUN it may show partially updated words.

## Timing
- Frame accepted in cycle t gives RUN at `k`=0..3 in cycles t+1..t+4, and `out_valid`=1 from cycle t+5. Latency is 5 cycles.
- **Throughput:** one frame per 5 cycles with `out_ready` held at 1. This relies on the new frame being accepted in the same cycle as the output handshake.
- `in_ready` depends combinationally on `out_ready`. Stage 4 must not derive `out_ready` combinationally from `in_ready`.
- **Under backpressure:** `Bus_out` and `out_valid` stay stable until the output handshake, and `in_ready` stays 0.
- Each cycle with `en` low adds exactly one cycle of latency.

## Structure
- **Shared package `fft_pkg`:**
  - `N_PTS`, `WORD_W`.
  - `TW_0`, `TW_4`.
  - The state enum (IDLE/RUN/DONE).
- **Sub-module:** the existing `SandeTukey` butterfly, instantiated twice (units A/B).
- **Operand selection:** 4:1 muxes on `k`.
- **Result write:** decoded by `k`.

## Test plan
- **Reset:** hold `reset` 3 cycles, then release → `in_ready`=1, `out_valid`=0, `Bus_out`=0. Assert `in_valid` during reset → frame not accepted.
- **Single frame:** inputs `Din[0]`=32'h0100_0000, `Din[2]`=32'h0040_0000, `Din[1]`=32'h0100_0000, all others 0. Expected at cycle t+5 with `out_valid`=1:
  - `Dout[0]`=32'h0140_0000, `Dout[2]`=32'h00C0_0000.
  - `Dout[1]`=32'h0100_0000, `Dout[3]`=32'h0000_FF00.
  - All others 0.
- **Backpressure:** `out_ready`=0 for 10 cycles after `out_valid` rises → `Bus_out` unchanged and `in_ready`=0 throughout. Raising `out_ready` completes the handshake in that cycle.
- **Back-to-back:** `in_valid` and `out_ready` held at 1 with 4 distinct random frames → accepts every 5 cycles, and every output matches the golden DIF Stage-3 model.
- **`en` stall:** drop `en` for 3 cycles at `k`=1 → `out_valid` rises at t+8, with results identical to the unstalled run.
- **Reset mid-RUN:** assert `reset` at `k`=2 → next cycle `out_valid`=0 and `Bus_out`=0. After release `in_ready`=1, and no stale frame is ever presented.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants for the folded 16-point radix-2 DIF FFT stages.
package fft_pkg;

  localparam int N_PTS  = 16;
  localparam int WORD_W = 32;

  // Q2.14 twiddles, {re, im}
  localparam logic [31:0] TW_0 = 32'h4000_0000;  // 1
  localparam logic [31:0] TW_4 = 32'h0000_C000;  // -j

  // Controller states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/stag3_folded_sandetukey.sv
// Sande-Tukey (DIF) radix-2 butterfly: x = a + b, y = (a - b) * w.
// Words are {re[31:16], im[15:0]}; w is Q2.14. All sums wrap at 16 bits.
module SandeTukey (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] w,
  output logic [31:0] x,
  output logic [31:0] y
);

  logic signed [15:0] ar, ai, br, bi, wr, wi;
  logic signed [15:0] dr, di;
  logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [32:0] yr_full, yi_full;
  logic               unused_bits;

  assign ar = a[31:16];
  assign ai = a[15:0];
  assign br = b[31:16];
  assign bi = b[15:0];
  assign wr = w[31:16];
  assign wi = w[15:0];

  assign dr = ar - br;
  assign di = ai - bi;

  assign p_rr = dr * wr;
  assign p_ii = di * wi;
  assign p_ri = dr * wi;
  assign p_ir = di * wr;

  assign yr_full = $signed({p_rr[31], p_rr}) - $signed({p_ii[31], p_ii});
  assign yi_full = $signed({p_ri[31], p_ri}) + $signed({p_ir[31], p_ir});

  // Arithmetic shift by 14, then keep the low 16 bits of each component.
  assign x = {16'(ar + br), 16'(ai + bi)};
  assign y = {yr_full[29:14], yi_full[29:14]};

  assign unused_bits = ^{yr_full[32:30], yr_full[13:0], yi_full[32:30], yi_full[13:0]};

endmodule

// File: rtl/stag3_folded.sv
// Folded Stage 3 of the 16-point DIF FFT: eight stride-2 butterflies on two
// shared units over four cycles, with valid/ready on both sides.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | waiting for a frame
//   RUN     | processing group k (k = 0..3), one group per cycle
//   DONE    | result held on Bus_out until Stage 4 takes it
module stag3_folded
  import fft_pkg::*;
#(
  parameter int N_PTS  = fft_pkg::N_PTS,
  parameter int WORD_W = fft_pkg::WORD_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_PTS*WORD_W-1:0]   Bus_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_PTS*WORD_W-1:0]   Bus_out
);

  state_t                    state;
  logic [1:0]                k;
  logic [N_PTS*WORD_W-1:0]   frame_q;
  logic [N_PTS*WORD_W-1:0]   result_q;
  logic                      accept;
  logic [31:0]               a_top, a_bot, b_top, b_bot;
  logic [31:0]               a_x, a_y, b_x, b_y;

  // Handshakes; both sides are blocked while reset is high or en is low.
  always_comb begin
    in_ready  = en && !reset &&
                ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
    out_valid = en && !reset && (state == ST_DONE);
    accept    = in_valid && in_ready;
  end

  // Group k operands: unit A takes words 4k / 4k+2, unit B 4k+1 / 4k+3.
  always_comb begin
    a_top = frame_q[{k, 2'b00, 5'd0} +: 32];
    a_bot = frame_q[{k, 2'b10, 5'd0} +: 32];
    b_top = frame_q[{k, 2'b01, 5'd0} +: 32];
    b_bot = frame_q[{k, 2'b11, 5'd0} +: 32];
  end

  SandeTukey u_bfly_a (
    .a (a_top),
    .b (a_bot),
    .w (TW_0),
    .x (a_x),
    .y (a_y)
  );

  SandeTukey u_bfly_b (
    .a (b_top),
    .b (b_bot),
    .w (TW_4),
    .x (b_x),
    .y (b_y)
  );

  // Controller, frame capture and per-group result write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      k        <= 2'd0;
      frame_q  <= '0;
      result_q <= '0;
    end else if (en) begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            frame_q <= Bus_in;
            k       <= 2'd0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          result_q[{k, 2'b00, 5'd0} +: 32] <= a_x;
          result_q[{k, 2'b10, 5'd0} +: 32] <= a_y;
          result_q[{k, 2'b01, 5'd0} +: 32] <= b_x;
          result_q[{k, 2'b11, 5'd0} +: 32] <= b_y;
          k <= k + 2'd1;
          if (k == 2'd3) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            if (accept) begin
              frame_q <= Bus_in;
              k       <= 2'd0;
              state   <= ST_RUN;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Bus_out = result_q;

endmodule

// File: tb/tb_stag3_folded.sv
// Self-checking bench for stag3_folded with a behavioural DIF stage-3 model.
module tb_stag3_folded;

  logic         clk = 1'b0;
  logic         reset, en, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [511:0] Bus_in, Bus_out;

  int n_cmp = 0;
  int n_bad = 0;

  stag3_folded dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Bus_in    (Bus_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Bus_out   (Bus_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock edge, then settle; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
  endfunction

  // Stage 3 of a 16-point DIF FFT: pairs (n, n+2) for every n with bit 1
  // clear; twiddle W16^(4*(n mod 2)), i.e. 1 for even n, -j for odd n.
  function automatic logic [511:0] model(input logic [511:0] fin);
    logic [511:0] fo;
    int ar, ai, br, bi, dr, di, wr, wi, yr, yi, xr, xi;
    logic [31:0] wa, wb;
    fo = '0;
    for (int n = 0; n < 16; n++) begin
      if ((n & 2) == 0) begin
        wa = fin[32*n +: 32];
        wb = fin[32*(n+2) +: 32];
        ar = int'($signed(wa[31:16]));
        ai = int'($signed(wa[15:0]));
        br = int'($signed(wb[31:16]));
        bi = int'($signed(wb[15:0]));
        xr = wrap16(ar + br);
        xi = wrap16(ai + bi);
        dr = wrap16(ar - br);
        di = wrap16(ai - bi);
        if (n % 2 == 0) begin wr = 16384; wi = 0; end
        else            begin wr = 0;     wi = -16384; end
        yr = wrap16((dr * wr - di * wi) >>> 14);
        yi = wrap16((dr * wi + di * wr) >>> 14);
        fo[32*n +: 32]     = {16'(xr), 16'(xi)};
        fo[32*(n+2) +: 32] = {16'(yr), 16'(yi)};
      end
    end
    return fo;
  endfunction

  function automatic logic [511:0] rand_frame();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[32*i +: 32] = $urandom;
    return f;
  endfunction

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; Bus_in = rand_frame();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold: in_ready=%b out_valid=%b, need 0/0", in_ready, out_valid);
      end
    end
    reset = 1'b0; in_valid = 1'b0;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, need 1/0", in_ready, out_valid);
    end
    n_cmp++;
    if (Bus_out !== '0) begin
      n_bad++;
      $display("FAIL reset_bus: got %h need 0", Bus_out);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_no_accept: out_valid=%b at cycle %0d, need 0", out_valid, i);
      end
    end
  endtask

  // Accept one frame and wait until cycle t+5; returns at t+5.
  task automatic run_frame(input logic [511:0] f, input string name);
    Bus_in = f; in_valid = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_ready: in_ready=%b need 1", name, in_ready);
    end
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_busy: t+%0d out_valid=%b in_ready=%b need 0/0", name, i, out_valid, in_ready);
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_latency: out_valid=%b at t+5 need 1", name, out_valid);
    end
    n_cmp++;
    if (Bus_out !== model(f)) begin
      n_bad++;
      $display("FAIL %s_data: got %h need %h", name, Bus_out, model(f));
    end
  endtask

  task automatic test_single();
    logic [511:0] f, e;
    f = '0;
    f[0*32 +: 32] = 32'h0100_0000;
    f[2*32 +: 32] = 32'h0040_0000;
    f[1*32 +: 32] = 32'h0100_0000;
    e = '0;
    e[0*32 +: 32] = 32'h0140_0000;
    e[2*32 +: 32] = 32'h00C0_0000;
    e[1*32 +: 32] = 32'h0100_0000;
    e[3*32 +: 32] = 32'h0000_FF00;
    out_ready = 1'b1;
    run_frame(f, "single");
    n_cmp++;
    if (Bus_out !== e) begin
      n_bad++;
      $display("FAIL single_const: got %h need %h", Bus_out, e);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_release: out_valid=%b in_ready=%b need 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] f, held;
    f = rand_frame();
    out_ready = 1'b0;
    run_frame(f, "bp");
    held = Bus_out;
    in_valid = 1'b1; Bus_in = rand_frame();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || Bus_out !== model(f)) begin
        n_bad++;
        $display("FAIL bp_hold: cycle %0d out_valid=%b in_ready=%b bus %h need 1/0 %h",
                 i, out_valid, in_ready, Bus_out, model(f));
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b need 1/1", out_valid, in_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || Bus_out !== held) begin
      n_bad++;
      $display("FAIL bp_done: out_valid=%b need 0 (bus %h vs %h)", out_valid, Bus_out, held);
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] fr[4];
    for (int f = 0; f < 4; f++) fr[f] = rand_frame();
    out_ready = 1'b1; in_valid = 1'b1; Bus_in = fr[0];
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_first_ready: in_ready=%b need 1", in_ready);
    end
    for (int f = 0; f < 4; f++) begin
      tick();
      if (f == 3) in_valid = 1'b0;
      else        Bus_in = fr[f+1];
      for (int i = 1; i < 5; i++) begin
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_busy: frame %0d t+%0d out_valid=%b in_ready=%b", f, i, out_valid, in_ready);
        end
        tick();
      end
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || Bus_out !== model(fr[f])) begin
        n_bad++;
        $display("FAIL b2b_out: frame %0d out_valid=%b in_ready=%b got %h need %h",
                 f, out_valid, in_ready, Bus_out, model(fr[f]));
      end
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_drain: out_valid=%b need 0", out_valid);
    end
  endtask

  task automatic test_en_stall();
    logic [511:0] f;
    f = rand_frame();
    out_ready = 1'b1; in_valid = 1'b1; Bus_in = f;
    tick();
    in_valid = 1'b0;
    tick();
    en = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_gate: in_ready=%b out_valid=%b need 0/0", in_ready, out_valid);
    end
    repeat (3) tick();
    en = 1'b1;
    for (int i = 5; i < 8; i++) begin
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_early: out_valid=%b at t+%0d need 0", out_valid, i);
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b1 || Bus_out !== model(f)) begin
      n_bad++;
      $display("FAIL stall_out: out_valid=%b got %h need 1 %h", out_valid, Bus_out, model(f));
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    out_ready = 1'b1; in_valid = 1'b1; Bus_in = rand_frame();
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || Bus_out !== '0) begin
      n_bad++;
      $display("FAIL midrun_reset: out_valid=%b in_ready=%b bus %h need 0/0/0", out_valid, in_ready, Bus_out);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midrun_ready: in_ready=%b need 1", in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL midrun_stale: out_valid=%b at cycle %0d need 0", out_valid, i);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; Bus_in = '0;
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_en_stall();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
